// File: rtl/ir_prefetch_queue_if.sv
// Fetch/issue bundle for ir_prefetch_queue: fetch handshake, control inputs and the decoded IR view.
interface ir_prefetch_queue_if #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned OPCODE_WIDTH = 4
);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned OPERAND_W = DATA_WIDTH - OPCODE_WIDTH;

    logic                    fetch_valid;
    logic [DATA_WIDTH-1:0]   fetch_data;
    logic                    fetch_ready;
    logic                    advance;
    logic                    flush;
    logic                    ir_valid;
    logic [DATA_WIDTH-1:0]   ir_out;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [OPERAND_W-1:0]    operand;
    logic [CNT_W-1:0]        count;

    modport master (
        output fetch_valid, fetch_data, advance, flush,
        input  fetch_ready, ir_valid, ir_out, opcode, operand, count
    );

    modport slave (
        input  fetch_valid, fetch_data, advance, flush,
        output fetch_ready, ir_valid, ir_out, opcode, operand, count
    );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry circular prefetch queue, with branch flush and opcode/operand split.
// Optional macro IR_STALL_COUNT_EN adds a saturating 16-bit count of cycles with no valid instruction.
module ir_prefetch_queue #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned OPCODE_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    ir_prefetch_queue_if.slave    bus
`ifdef IR_STALL_COUNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned OPERAND_W = DATA_WIDTH - OPCODE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  ir_valid_q;
    logic [DATA_WIDTH-1:0] ir_q;

    logic ready_c;
    logic xfer_c;
    logic load_c;
    logic pop_c;
    logic bypass_c;
    logic push_c;

    // Handshake and queue-movement decode; a word bypasses straight into the IR only when nothing is queued.
    always_comb begin
        ready_c  = (cnt != CNT_W'(DEPTH)) && !bus.flush;
        xfer_c   = bus.fetch_valid && ready_c;
        load_c   = !ir_valid_q || bus.advance;
        pop_c    = load_c && (cnt != '0) && !bus.flush;
        bypass_c = load_c && (cnt == '0) && xfer_c;
        push_c   = xfer_c && !bypass_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            ir_valid_q <= 1'b0;
            ir_q       <= '0;
        end else if (bus.flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            if (load_c) begin
                if (pop_c) begin
                    ir_q       <= mem[rd_ptr];
                    ir_valid_q <= 1'b1;
                    rd_ptr     <= rd_ptr + PTR_W'(1);
                end else if (bypass_c) begin
                    ir_q       <= bus.fetch_data;
                    ir_valid_q <= 1'b1;
                end else begin
                    ir_valid_q <= 1'b0;
                end
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Queue storage is not reset; entries are only read after being written.
    always_ff @(posedge clock) begin
        if (push_c && !reset) begin
            mem[wr_ptr] <= bus.fetch_data;
        end
    end

`ifdef IR_STALL_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!ir_valid_q && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'(1);
        end
    end
`endif

    assign bus.fetch_ready = ready_c;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.ir_out      = ir_q;
    assign bus.opcode      = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign bus.operand     = ir_q[OPERAND_W-1:0];
    assign bus.count       = cnt;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Self-checking bench for ir_prefetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_ir_prefetch_queue;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OW    = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ir_prefetch_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OPCODE_WIDTH(OW)) bus ();

`ifdef IR_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    ir_prefetch_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .OPCODE_WIDTH(OW)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus)
`ifdef IR_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queued words behind the IR, plus the IR itself.
    logic [DW-1:0] q [$];
    bit            m_iv;
    logic [DW-1:0] m_ir;
    int unsigned   m_stall;
    bit            obs_ready;
    bit            last_xfer;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("ir_valid", 32'(bus.ir_valid), 32'(m_iv));
        check_val("ir_out",   32'(bus.ir_out),   32'(m_ir));
        check_val("opcode",   32'(bus.opcode),   32'(m_ir) >> (DW - OW));
        check_val("operand",  32'(bus.operand),  32'(m_ir) % (32'd1 << (DW - OW)));
        check_val("count",    32'(bus.count),    32'(q.size()));
`ifdef IR_STALL_COUNT_EN
        check_val("stall_count", 32'(stall_count), m_stall);
`endif
    endtask

    // One clock: drive inputs, check ready before the edge, advance the model, check outputs after.
    task automatic step(input bit rst, input bit fv, input logic [DW-1:0] fd, input bit adv, input bit fl);
        bit exp_ready;
        reset           = rst;
        bus.fetch_valid = fv;
        bus.fetch_data  = fd;
        bus.advance     = adv;
        bus.flush       = fl;
        #1;
        exp_ready = (q.size() != DEPTH) && !fl;
        obs_ready = bus.fetch_ready;
        if (!rst) check_val("fetch_ready", 32'(bus.fetch_ready), 32'(exp_ready));
        last_xfer = fv && exp_ready && !rst;
        @(posedge clock);
        if (rst) m_stall = 0;
        else if (!m_iv && m_stall != 32'hFFFF) m_stall++;
        if (rst) begin
            q.delete(); m_iv = 0; m_ir = '0;
        end else if (fl) begin
            q.delete(); m_iv = 0;
        end else if (!m_iv || adv) begin
            if (q.size() != 0) begin
                m_ir = q.pop_front(); m_iv = 1;
                if (last_xfer) q.push_back(fd);
            end else if (last_xfer) begin
                m_ir = fd; m_iv = 1;
            end else begin
                m_iv = 0;
            end
        end else if (last_xfer) begin
            q.push_back(fd);
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    initial begin
        m_iv = 0; m_ir = '0; m_stall = 0;

        // Reset two cycles after a word was loaded
        step(1, 0, '0, 0, 0);
        step(0, 1, 16'h1234, 0, 0);
        idle(2);
        step(1, 0, '0, 0, 0);
        check_val("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_val("rst_ir_out",   32'(bus.ir_out),   32'd0);
        check_val("rst_opcode",   32'(bus.opcode),   32'd0);
        check_val("rst_operand",  32'(bus.operand),  32'd0);
        check_val("rst_count",    32'(bus.count),    32'd0);
        check_val("rst_ready",    32'(bus.fetch_ready), 32'd1);

        // Bypass into an empty IR
        step(0, 1, 16'h1234, 0, 0);
        check_val("byp_ir_out",  32'(bus.ir_out),  32'h1234);
        check_val("byp_opcode",  32'(bus.opcode),  32'h1);
        check_val("byp_operand", 32'(bus.operand), 32'h234);
        check_val("byp_count",   32'(bus.count),   32'd0);

        // Fill: 0x0006 is refused once the queue is full
        step(1, 0, '0, 0, 0);
        for (int w = 1; w <= 6; w++) step(0, 1, 16'(w), 0, 0);
        step(0, 1, 16'h0006, 0, 0);
        check_val("fill_ir_out", 32'(bus.ir_out),      32'h0001);
        check_val("fill_count",  32'(bus.count),       32'd4);
        check_val("fill_ready",  32'(bus.fetch_ready), 32'd0);

        // Drain with 0x0006 still offered until accepted
        begin
            bit pending = 1;
            for (int k = 0; k < 5; k++) begin
                step(0, pending, 16'h0006, 1, 0);
                if (k == 1) check_val("drain_ready_back", 32'(obs_ready), 32'd1);
                if (last_xfer) pending = 0;
                check_val("drain_ir_out", 32'(bus.ir_out), 32'(k + 2));
                check_val("drain_valid",  32'(bus.ir_valid), 32'd1);
            end
            check_val("drain_accepted", 32'(pending), 32'd0);
        end

        // Simultaneous push and pop keeps count steady
        step(1, 0, '0, 0, 0);
        step(0, 1, 16'h0010, 0, 0);
        step(0, 1, 16'h0011, 0, 0);
        step(0, 1, 16'h0012, 0, 0);
        step(0, 1, 16'h00AA, 1, 0);
        check_val("sim_count",  32'(bus.count),  32'd2);
        check_val("sim_ir_out", 32'(bus.ir_out), 32'h0011);
        step(0, 0, '0, 1, 0);
        check_val("sim_next1", 32'(bus.ir_out), 32'h0012);
        step(0, 0, '0, 1, 0);
        check_val("sim_next2", 32'(bus.ir_out), 32'h00AA);

        // Flush discards everything and blocks the offered word
        step(1, 0, '0, 0, 0);
        for (int w = 0; w < 4; w++) step(0, 1, 16'(16'h0020 + w), 0, 0);
        check_val("pre_flush_count", 32'(bus.count), 32'd3);
        step(0, 1, 16'h0BAD, 1, 1);
        check_val("flush_ready",    32'(obs_ready),    32'd0);
        check_val("flush_ir_valid", 32'(bus.ir_valid), 32'd0);
        check_val("flush_count",    32'(bus.count),    32'd0);
        step(0, 1, 16'h0C00, 0, 0);
        check_val("post_flush_ir", 32'(bus.ir_out),   32'h0C00);
        check_val("post_flush_iv", 32'(bus.ir_valid), 32'd1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) == 0,
                 ($urandom % 4) != 0,
                 16'($urandom),
                 ($urandom % 2) == 1,
                 $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
